// File: rtl/truth_table_sweeper_if.sv
// rtl/truth_table_sweeper_if.sv - stimulus/response and status bundle for truth_table_sweeper
//
// Purpose: groups the sweep control, DUT drive/response and result signals.
// Modports:
//   slave  - the sweeper: takes start and dut_out, drives dut_in and all status
//   master - the harness: drives start and dut_out, observes everything else
// Signals: start, dut_in[N_IN], dut_out[N_OUT], busy, done, pass,
//          err_count[N_IN+1], fail_valid, first_fail[N_IN]

interface truth_table_sweeper_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 1
);
  logic              start;
  logic [N_IN-1:0]   dut_in;
  logic [N_OUT-1:0]  dut_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N_IN:0]     err_count;
  logic              fail_valid;
  logic [N_IN-1:0]   first_fail;

  modport slave (
    input  start, dut_out,
    output dut_in, busy, done, pass, err_count, fail_valid, first_fail
  );

  modport master (
    output start, dut_out,
    input  dut_in, busy, done, pass, err_count, fail_valid, first_fail
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive truth-table stimulus and checker for combinational DUTs
//
// Purpose: drives every N_IN-bit vector in ascending order, holds each for
// HOLD_CYCLES clocks, samples dut_out on the last clock of the hold and
// compares it with the packed EXP_TABLE entry for that vector.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset; abandons any sweep in progress
//   bus  - truth_table_sweeper_if.slave (start, dut_in, dut_out, busy, done,
//          pass, err_count, fail_valid, first_fail); all outputs registered
// Build option: define STOP_ON_FAIL_EN to end the sweep at the first mismatch.

module truth_table_sweeper #(
  parameter int N_IN        = 4,
  parameter int N_OUT       = 1,
  parameter int HOLD_CYCLES = 20,
  parameter logic [(2**N_IN)*N_OUT-1:0] EXP_TABLE = 16'h6996
) (
  input  logic clk,
  input  logic rst,
  truth_table_sweeper_if.slave bus
);

`ifdef STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  // Counter holds HOLD_CYCLES-1 down to 0; keep at least one bit for HOLD_CYCLES=1.
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN:0]   err_q, err_d;
  logic            fv_q, fv_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;

  logic [N_OUT-1:0] exp_entry;
  logic             sample;
  logic             mismatch;
  logic             start_ok;

  always_comb begin
    exp_entry = EXP_TABLE[int'(vec_q) * N_OUT +: N_OUT];
  end

  assign sample   = (state_q == S_HOLD) && (cnt_q == '0);
  assign mismatch = sample && (bus.dut_out != exp_entry);
  // start is only honoured when no sweep is running
  assign start_ok = bus.start && (state_q != S_HOLD);

  // State register and all output/datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ff_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_ok) state_d = S_HOLD;
      S_HOLD: begin
        if (sample && ((vec_q == VEC_LAST) || (STOP_ON_FAIL && mismatch)))
          state_d = S_DONE;
      end
      S_DONE: if (start_ok) state_d = S_HOLD;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    cnt_d = cnt_q;
    vec_d = vec_q;
    err_d = err_q;
    fv_d  = fv_q;
    ff_d  = ff_q;
    if (start_ok) begin
      cnt_d = CNT_RELOAD;
      vec_d = '0;
      err_d = '0;
      fv_d  = 1'b0;
      ff_d  = '0;
    end else if (state_q == S_HOLD) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else begin
        if (mismatch) begin
          // Cannot wrap: at most 2**N_IN mismatches fit in N_IN+1 bits.
          err_d = err_q + {{N_IN{1'b0}}, 1'b1};
          if (!fv_q) begin
            fv_d = 1'b1;
            ff_d = vec_q;
          end
        end
        // Advance only while staying in HOLD so dut_in keeps the last vector in DONE.
        if (state_d == S_HOLD) begin
          vec_d = vec_q + {{(N_IN-1){1'b0}}, 1'b1};
          cnt_d = CNT_RELOAD;
        end
      end
    end
    busy_d = (state_d == S_HOLD);
    done_d = (state_d == S_DONE);
    pass_d = (state_d == S_DONE) && (err_d == '0);
  end

  assign bus.dut_in     = vec_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.fail_valid = fv_q;
  assign bus.first_fail = ff_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - directed self-checking bench for truth_table_sweeper

module tb_truth_table_sweeper;

`ifdef STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   mode = 0;   // 0: XOR DUT, 1: wrong at 5 and 12, 2: tied to 0

  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(4), .N_OUT(1)) bus ();
  truth_table_sweeper_if #(.N_IN(2), .N_OUT(2)) sbus ();

  truth_table_sweeper #(
    .N_IN(4), .N_OUT(1), .HOLD_CYCLES(4), .EXP_TABLE(16'h6996)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  truth_table_sweeper #(
    .N_IN(2), .N_OUT(2), .HOLD_CYCLES(1), .EXP_TABLE(8'b11_10_01_00)
  ) u_small (
    .clk(clk), .rst(rst), .bus(sbus.slave)
  );

  always_comb begin
    case (mode)
      1:       bus.dut_out = ^bus.dut_in ^ ((bus.dut_in == 4'd5) || (bus.dut_in == 4'd12));
      2:       bus.dut_out = 1'b0;
      default: bus.dut_out = ^bus.dut_in;
    endcase
  end

  assign sbus.dut_out = sbus.dut_in;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after an edge; leaves us #1 after the start-sampling edge k.
  task automatic start_sweep();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 300) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.dut_in !== 4'd0) begin errors++; $display("FAIL reset_dut_in got=%0d exp=0", bus.dut_in); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.pass !== 1'b0) begin errors++; $display("FAIL reset_pass got=%b exp=0", bus.pass); end
    checks++; if (bus.err_count !== 5'd0) begin errors++; $display("FAIL reset_err got=%0d exp=0", bus.err_count); end
    checks++; if (bus.fail_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b exp=0", bus.fail_valid); end
    checks++; if (bus.first_fail !== 4'd0) begin errors++; $display("FAIL reset_ff got=%0d exp=0", bus.first_fail); end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_pass_sweep();
    int bad;
    mode = 0;
    start_sweep();
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (bus.dut_in !== 4'(i / 4) || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        if (bad == 0) $display("FAIL sweep_step cycle=%0d got dut_in=%0d busy=%b done=%b exp dut_in=%0d busy=1 done=0",
                               i, bus.dut_in, bus.busy, bus.done, i / 4);
        bad++;
      end
      step();
    end
    checks++; if (bad != 0) errors++;
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL sweep_done_at_64 got done=%b busy=%b exp done=1 busy=0", bus.done, bus.busy); end
    checks++; if (bus.pass !== 1'b1) begin errors++; $display("FAIL sweep_pass got=%b exp=1", bus.pass); end
    checks++; if (bus.err_count !== 5'd0) begin errors++; $display("FAIL sweep_err got=%0d exp=0", bus.err_count); end
    checks++; if (bus.fail_valid !== 1'b0 || bus.first_fail !== 4'd0) begin errors++; $display("FAIL sweep_fv got fv=%b ff=%0d exp fv=0 ff=0", bus.fail_valid, bus.first_fail); end
    checks++; if (bus.dut_in !== 4'd15) begin errors++; $display("FAIL sweep_hold_last got=%0d exp=15", bus.dut_in); end
  endtask

  task automatic test_two_errors();
    int n;
    mode = 1;
    start_sweep();
    wait_done(n);
    checks++; if (n != (STOP ? 24 : 64)) begin errors++; $display("FAIL two_err_latency got=%0d exp=%0d", n, STOP ? 24 : 64); end
    checks++; if (bus.err_count !== (STOP ? 5'd1 : 5'd2)) begin errors++; $display("FAIL two_err_count got=%0d exp=%0d", bus.err_count, STOP ? 1 : 2); end
    checks++; if (bus.first_fail !== 4'd5 || bus.fail_valid !== 1'b1) begin errors++; $display("FAIL two_err_first got ff=%0d fv=%b exp ff=5 fv=1", bus.first_fail, bus.fail_valid); end
    checks++; if (bus.pass !== 1'b0) begin errors++; $display("FAIL two_err_pass got=%b exp=0", bus.pass); end
    checks++; if (bus.dut_in !== (STOP ? 4'd5 : 4'd15)) begin errors++; $display("FAIL two_err_dut_in got=%0d exp=%0d", bus.dut_in, STOP ? 5 : 15); end
  endtask

  task automatic test_tied_zero();
    int n;
    mode = 2;
    start_sweep();
    wait_done(n);
    checks++; if (n != (STOP ? 8 : 64)) begin errors++; $display("FAIL tied0_latency got=%0d exp=%0d", n, STOP ? 8 : 64); end
    checks++; if (bus.err_count !== (STOP ? 5'd1 : 5'd8)) begin errors++; $display("FAIL tied0_count got=%0d exp=%0d", bus.err_count, STOP ? 1 : 8); end
    checks++; if (bus.first_fail !== 4'd1) begin errors++; $display("FAIL tied0_first got=%0d exp=1", bus.first_fail); end
    checks++; if (bus.pass !== 1'b0) begin errors++; $display("FAIL tied0_pass got=%b exp=0", bus.pass); end
  endtask

  task automatic test_reset_mid();
    int n;
    mode = 0;
    start_sweep();
    for (int i = 0; i < 38; i++) step();
    checks++; if (bus.dut_in !== 4'd9) begin errors++; $display("FAIL mid_vector got=%0d exp=9", bus.dut_in); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.dut_in !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pass !== 1'b0 ||
                  bus.err_count !== 5'd0 || bus.fail_valid !== 1'b0 || bus.first_fail !== 4'd0) begin
      errors++;
      $display("FAIL mid_async_reset got dut_in=%0d busy=%b done=%b pass=%b err=%0d fv=%b ff=%0d exp all 0",
               bus.dut_in, bus.busy, bus.done, bus.pass, bus.err_count, bus.fail_valid, bus.first_fail);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_no_resume got busy=%b exp=0", bus.busy); end
    start_sweep();
    checks++; if (bus.dut_in !== 4'd0) begin errors++; $display("FAIL mid_restart_vec got=%0d exp=0", bus.dut_in); end
    wait_done(n);
    checks++; if (n != 64 || bus.pass !== 1'b1) begin errors++; $display("FAIL mid_full_sweep got n=%0d pass=%b exp n=64 pass=1", n, bus.pass); end
  endtask

  task automatic test_start_held();
    int n;
    mode = 2;
    bus.start = 1'b1;
    step();
    wait_done(n);
    checks++; if (n != (STOP ? 8 : 64)) begin errors++; $display("FAIL held_no_restart got=%0d exp=%0d", n, STOP ? 8 : 64); end
    checks++; if (bus.err_count !== (STOP ? 5'd1 : 5'd8)) begin errors++; $display("FAIL held_first_err got=%0d exp=%0d", bus.err_count, STOP ? 1 : 8); end
    step();
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.dut_in !== 4'd0) begin errors++; $display("FAIL held_restart got done=%b busy=%b dut_in=%0d exp done=0 busy=1 dut_in=0", bus.done, bus.busy, bus.dut_in); end
    checks++; if (bus.err_count !== 5'd0 || bus.fail_valid !== 1'b0 || bus.first_fail !== 4'd0) begin errors++; $display("FAIL held_cleared got err=%0d fv=%b ff=%0d exp 0 0 0", bus.err_count, bus.fail_valid, bus.first_fail); end
    mode = 0;
    bus.start = 1'b0;
    wait_done(n);
    checks++; if (n != 64 || bus.pass !== 1'b1) begin errors++; $display("FAIL held_second got n=%0d pass=%b exp n=64 pass=1", n, bus.pass); end
  endtask

  task automatic test_small();
    int n;
    int bad;
    sbus.start = 1'b1;
    step();
    sbus.start = 1'b0;
    bad = 0;
    n = 0;
    while (!sbus.done && n < 20) begin
      if (sbus.dut_in !== 2'(n)) begin
        bad++;
        $display("FAIL small_vec cycle=%0d got=%0d exp=%0d", n, sbus.dut_in, n);
      end
      step();
      n++;
    end
    checks++; if (bad != 0) errors++;
    checks++; if (n != 4) begin errors++; $display("FAIL small_latency got=%0d exp=4", n); end
    checks++; if (sbus.pass !== 1'b1 || sbus.err_count !== 3'd0) begin errors++; $display("FAIL small_pass got pass=%b err=%0d exp pass=1 err=0", sbus.pass, sbus.err_count); end
  endtask

  initial begin
    bus.start  = 1'b0;
    sbus.start = 1'b0;
    test_reset();
    test_pass_sweep();
    test_two_errors();
    test_tied_zero();
    test_reset_mid();
    test_start_held();
    test_small();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
